// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: byte-level UART receiver feeding the command decoders.
// 16x oversampling, majority vote over sub-samples 7/8/9, false-start
// rejection, framing-error and (optional) parity-error pulses.
// Optional even-parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_cmd #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  output logic [7:0] po_data,
  output logic       rx_down,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      sc_q;
  logic [2:0]      bitidx_q;
  logic [7:0]      shreg_q;
  logic            samp7_q, samp8_q;
`ifdef UART_RX_PARITY_EN
  logic            perr_q;
`endif

  logic tick_d, maj_d, fall_d;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= line_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Oversample tick, start edge and 2-of-3 vote using the live sample at sc=9.
  always_comb begin
    tick_d = (cnt_q == DIV_M1);
    fall_d = prev_q & ~sync2_q;
    maj_d  = (samp7_q & samp8_q) | (samp7_q & sync2_q) | (samp8_q & sync2_q);
  end

  // Receive FSM with registered data and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sc_q      <= '0;
      bitidx_q  <= '0;
      shreg_q   <= '0;
      samp7_q   <= 1'b0;
      samp8_q   <= 1'b0;
      po_data   <= '0;
      rx_down   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_down   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state_q == S_IDLE) begin
        busy <= 1'b0;
        if (fall_d) begin
          state_q <= S_START;
          cnt_q   <= '0;
          sc_q    <= '0;
          busy    <= 1'b1;
        end
      end else begin
        cnt_q <= tick_d ? '0 : cnt_q + CW'(1);
        if (tick_d) begin
          sc_q <= sc_q + 4'd1;
          if (sc_q == 4'd7) samp7_q <= sync2_q;
          if (sc_q == 4'd8) samp8_q <= sync2_q;
          case (state_q)
            S_START: begin
              if (sc_q == 4'd9 && maj_d) begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
              end else if (sc_q == 4'd15) begin
                state_q  <= S_DATA;
                bitidx_q <= '0;
              end
            end
            S_DATA: begin
              if (sc_q == 4'd9) shreg_q <= {maj_d, shreg_q[7:1]};
              if (sc_q == 4'd15) begin
                if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_q <= S_PARITY;
`else
                  state_q <= S_STOP;
`endif
                end else begin
                  bitidx_q <= bitidx_q + 3'd1;
                end
              end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
              if (sc_q == 4'd9) perr_q <= maj_d ^ (^shreg_q);
              if (sc_q == 4'd15) state_q <= S_STOP;
            end
`endif
            S_STOP: begin
              // Leave at mid-stop so a following start edge is not missed.
              if (sc_q == 4'd9) begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
                if (!maj_d) begin
                  frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (perr_q) begin
                  parity_err <= 1'b1;
`endif
                end else begin
                  po_data <= shreg_q;
                  rx_down <= 1'b1;
                end
              end
            end
            default: begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb_uart_rx_cmd: scoreboard bench for uart_rx_cmd at DIV = 10 (160 cycles/bit).
// Frames are generated bit by bit at the pin; the expected outcome of each
// frame is derived from its contents and queued, and a monitor checks every
// output pulse against the queue head.
module tb_uart_rx_cmd;

  localparam int unsigned CLK_FREQ = 1_536_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned BITLEN   = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif

  localparam logic [1:0] K_RX = 2'd1, K_FE = 2'd2, K_PE = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk, rst_n, line_rx;
  logic [7:0] po_data;
  logic       rx_down, frame_err, parity_err, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  exp_t sb[$];
  int   rx_cyc[$];
  logic [7:0] model_po;

  uart_rx_cmd #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .line_rx(line_rx), .po_data(po_data),
    .rx_down(rx_down), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (rx_down || frame_err || parity_err)) begin
      logic [1:0] k;
      exp_t e;
      chk("single_pulse", 32'(int'(rx_down) + int'(frame_err) + int'(parity_err)), 32'd1);
      k = rx_down ? K_RX : (frame_err ? K_FE : K_PE);
      if (rx_down) rx_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(k), 32'(e.kind));
        chk("po_data", 32'(po_data), 32'(e.data));
      end
    end
  end

  // Reference model: outcome from stop bit, parity correctness and data.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_bad,
                            input int unsigned bl);
    exp_t e;
    logic [9:0] bits;
    if (!stop) begin
      e.kind = K_FE; e.data = model_po;
    end else if (PAR && par_bad) begin
      e.kind = K_PE; e.data = model_po;
    end else begin
      e.kind = K_RX; e.data = d; model_po = d;
    end
    sb.push_back(e);
    bits = {(^d) ^ par_bad, d, 1'b0};
    for (int unsigned i = 0; i < 9 + int'(PAR); i++) begin
      line_rx = bits[i];
      repeat (bl) @(negedge clk);
    end
    line_rx = stop;
    repeat (bl) @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    line_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int n0;
    logic [7:0] d;
    bit st, pb;
    model_po = 8'h00;
    rst_n   = 1'b0;
    line_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_po_data", 32'(po_data), 32'h00);
    chk("rst_rx_down", 32'(rx_down), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(20);

    // Good byte
    send_frame(8'h55, 1'b1, 1'b0, BITLEN);
    idle(50);
    chk("good_po_data", 32'(po_data), 32'h55);
    chk("good_busy_idle", 32'(busy), 32'd0);

    // False start: 30-cycle low glitch
    bcnt = 0;
    for (int i = 0; i < 250; i++) begin
      line_rx = (i < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("glitch_busy_seen", 32'(bcnt > 0), 32'd1);
    chk("glitch_busy_le100", 32'(bcnt <= 100), 32'd1);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    chk("glitch_po_hold", 32'(po_data), 32'h55);

    // Framing error after a good byte
    send_frame(8'h12, 1'b1, 1'b0, BITLEN);
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0, BITLEN);
    idle(60);
    chk("ferr_po_hold", 32'(po_data), 32'h12);

    // Back-to-back, zero idle gap
    n0 = rx_cyc.size();
    send_frame(8'hA1, 1'b1, 1'b0, BITLEN);
    send_frame(8'h0F, 1'b1, 1'b0, BITLEN);
    idle(40);
    chk("b2b_count", 32'(rx_cyc.size() - n0), 32'd2);
    if (rx_cyc.size() >= 2)
      chk("b2b_spacing", 32'(rx_cyc[rx_cyc.size()-1] - rx_cyc[rx_cyc.size()-2]),
          32'(FRAME_BITS * BITLEN));
    chk("b2b_po_data", 32'(po_data), 32'h0F);

    // Reset mid-frame during data bit 4 (no expectation queued)
    line_rx = 1'b0;
    repeat (BITLEN) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line_rx = i[0];
      repeat (BITLEN) @(negedge clk);
    end
    line_rx = 1'b1;
    repeat (BITLEN / 2) @(negedge clk);
    chk("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_po_data", 32'(po_data), 32'h00);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_pulses", 32'({rx_down, frame_err, parity_err}), 32'd0);
    model_po = 8'h00;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    send_frame(8'hC3, 1'b1, 1'b0, BITLEN);
    idle(40);
    chk("post_rst_po_data", 32'(po_data), 32'hC3);

    // Break: line held low yields a single framing error
    send_frame(8'h00, 1'b0, 1'b0, BITLEN);
    repeat (3000) @(negedge clk);
    chk("break_busy", 32'(busy), 32'd0);
    idle(60);
    chk("break_po_hold", 32'(po_data), 32'hC3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, BITLEN);
    idle(40);
    chk("perr_po_hold", 32'(po_data), 32'hC3);
    send_frame(8'h03, 1'b1, 1'b0, BITLEN);
    idle(40);
    chk("par_ok_po_data", 32'(po_data), 32'h03);
`endif

    // Randomized frames with up to about +-2% baud error
    for (int n = 0; n < 16; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = ($urandom_range(0, 5) == 0);
      send_frame(d, st, pb, $urandom_range(157, 163));
      if (st) idle($urandom_range(0, 30));
      else    idle(40);
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    idle(50);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_po_data", 32'(po_data), 32'(model_po));
    chk("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd.md
# uart_rx_cmd

Byte-level UART receiver that feeds the command decoders (`power_ly`, `power_voice`, `power_voice_wc`) with the `po_data` / `rx_down` pair they consume. It sits between the board RX pin and the decoders, one instance per serial source (host link and voice module). It uses 16x oversampling with majority-vote sampling and rejects false starts. It flags framing errors and, optionally, parity errors.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in baud.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `line_rx` input, 1 bit: asynchronous serial input, idle high.
- `po_data` output, 8 bits: last correctly received byte.
- `rx_down` output, 1 bit: one-cycle pulse, `po_data` newly valid.
- `frame_err` output, 1 bit: one-cycle pulse, stop bit sampled low.
- `parity_err` output, 1 bit: one-cycle pulse, parity mismatch; constant 0 when parity is compiled out.
- `busy` output, 1 bit: high from start-edge detection until return to IDLE.

## Operation
- **Divider.** DIV = CLK_FREQ/(BAUD*16), truncated, must be ≥ 1. The tick counter runs 0..DIV-1. A tick is one cycle where the counter equals DIV-1. The counter is cleared on start detection.
- **Input synchronizer.** `line_rx` passes through two flops, both reset to 1. A falling edge is detected on the synchronized value (previous 1, current 0).
- **Bit timing.** Each bit has a sub-counter `sc` running 0..15, advancing on each tick. Three samples are taken at sc = 7, 8, 9. The bit value is the majority of the three, decided at sc = 9.
- **State IDLE.** `busy` = 0. A falling edge moves to START with tick counter and `sc` cleared.
- **State START.**
  - Decided value 1: false start, return to IDLE. No pulse.
  - Decided value 0: at sc = 15 move to DATA with bit index 0.
- **State DATA.**
  - 8 bits, LSB first, shifted into `shreg` at sc = 9.
  - At sc = 15 of bit 7, move to PARITY if parity is compiled in, otherwise to STOP.
- **State PARITY.** The parity bit is decided at sc = 9 and compared against even parity of `shreg`. The result is latched; move to STOP at sc = 15.
- **State STOP.** Decided at sc = 9, then return to IDLE in the same cycle. Outcomes, checked in this order:
  - Stop = 0: `frame_err` pulses.
  - Parity mismatch: `parity_err` pulses.
  - Otherwise: `po_data` <= `shreg` and `rx_down` pulses.
  - Only one of the three pulses ever fires per frame.
- **Output hold.** `po_data` changes only on a good frame. Bad frames leave the previous byte.
- **Break condition.** Returning to IDLE at mid-stop allows back-to-back frames with no idle gap. A line held low (break) produces a single `frame_err` and no further activity until a new 1→0 edge.

## Timing
- **Reset values.** `po_data` = 8'h00; `rx_down`, `frame_err`, `parity_err`, `busy` = 0; state IDLE; synchronizer flops = 1.
- **Reset mid-frame.** Any reset assertion aborts immediately. No pulse is produced for the partial frame.
- **Start detection.** The falling edge at the pin reaches the edge detector 2 cycles later.
- **Latency.** `rx_down`, `frame_err` and `parity_err` assert one cycle after the mid-stop decision. That is about 9.5 bit times (10.5 with parity) after the start edge, plus 2 synchronizer cycles.
- **Pulse width.** All pulses are exactly 1 cycle wide and are registered outputs.
- **Glitch rejection.** A low glitch shorter than about 7/16 of a bit is rejected as a false start. `busy` falls within 10 ticks of the edge.
- **Tolerance.** Baud error up to ±3% is tolerated.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** frame is start, 8 data bits, even parity bit, stop. The PARITY state exists and `parity_err` is driven.
- **Undefined:** frame is 8N1. The PARITY state and its logic are absent and `parity_err` is tied to 0.

## Test plan
All scenarios use CLK_FREQ = 1_536_000 and BAUD = 9600, giving DIV = 10.
- **Good byte:** send 0x55 in 8N1 → one `rx_down` pulse, `po_data` = 0x55, `frame_err` stays 0, `busy` returns to 0.
- **False start:** 30-cycle low glitch on an idle line → no pulses, `busy` high for ≤ 100 cycles, then 0; `po_data` unchanged.
- **Framing error:** 0x3C sent after a good 0x12, with stop bit driven 0 → `frame_err` pulse, no `rx_down`, `po_data` stays 0x12.
- **Back-to-back:** 0xA1 then 0x0F with zero idle gap → two `rx_down` pulses spaced 160 × 10 cycles apart; `po_data` reads 0xA1, then 0x0F.
- **Reset mid-frame:** `rst_n` low during data bit 4 → all outputs at reset values immediately; next frame 0xC3 received correctly.
- **Parity (`UART_RX_PARITY_EN` defined):** 0x03 sent with parity bit 1 → `parity_err` pulse, no `rx_down`. Same byte with parity bit 0 → `rx_down`, `po_data` = 0x03.
